// File: rtl/prbs7_tx_pattern_gen_if.sv
// Control and data bundle for the transmit-side PRBS7 pattern generator.
//   enable      level request to generate words
//   seed        initial 7-bit LFSR history (bit 0 = oldest sequence bit)
//   slip        pulse: drop one extra sequence bit in the next word
//   inj_req     pulse: flip bit inj_bit of the next word
//   inj_bit     bit index to flip (modulo WORDWIDTH)
//   inj_period  0 = no automatic injection, N = flip every Nth RUN word
//   dout        registered PRBS word, dout[0] is the first serial bit
//   dout_valid  high while the generator is running
//   inj_count   saturating count of flipped words since reset
// modport master: the controlling side; modport slave: the generator.
interface prbs7_tx_pattern_gen_if #(
    parameter int WORDWIDTH = 64,
    parameter int CNTWIDTH  = 16
);
    logic                 enable;
    logic [6:0]           seed;
    logic                 slip;
    logic                 inj_req;
    logic [5:0]           inj_bit;
    logic [CNTWIDTH-1:0]  inj_period;
    logic [WORDWIDTH-1:0] dout;
    logic                 dout_valid;
    logic [CNTWIDTH-1:0]  inj_count;

    modport master (
        output enable, seed, slip, inj_req, inj_bit, inj_period,
        input  dout, dout_valid, inj_count
    );

    modport slave (
        input  enable, seed, slip, inj_req, inj_bit, inj_period,
        output dout, dout_valid, inj_count
    );
endinterface

// File: rtl/prbs7_tx_pattern_gen.sv
// Transmit-side PRBS7 (x^7 + x^6 + 1) word generator for the GT link test path.
// Emits one WORDWIDTH-bit word per clock, LSB first in serial order, with
// controllable single-bit error injection (manual and periodic) and one-bit
// sequence slips for exercising the receive aligner and error counters.
// Ports:
//   clk    tx user clock
//   reset  synchronous, active-high; overrides every other input
//   bus    slave side of prbs7_tx_pattern_gen_if (controls in, word/status out)
module prbs7_tx_pattern_gen #(
    parameter int WORDWIDTH = 64,
    parameter int CNTWIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    prbs7_tx_pattern_gen_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // History (7 bits) plus enough new bits for a word with one slipped bit.
    localparam int EXTW = WORDWIDTH + 8;

    // Extends the 7-bit history (bit 0 oldest) with s[n] = s[n-6] ^ s[n-7].
    function automatic logic [EXTW-1:0] prbs_extend(input logic [6:0] hist);
        logic [EXTW-1:0] ext;
        ext      = {EXTW{1'b0}};
        ext[6:0] = hist;
        for (int k = 0; k < EXTW - 7; k++) begin
            ext[k + 7] = ext[k + 1] ^ ext[k];
        end
        return ext;
    endfunction

    state_t               state_r, state_nxt_s;
    logic [6:0]           hist_r, hist_nxt_s, hist_src_s, hist_adv_s, seed_fix_s;
    logic [EXTW-1:0]      ext_s;
    logic [WORDWIDTH-1:0] word_s, mask_s, dout_r, dout_nxt_s;
    logic                 valid_r, valid_nxt_s;
    logic                 run_word_s, slip_s, per_evt_s, flip_s;
    logic [CNTWIDTH-1:0]  per_cnt_r, per_cnt_nxt_s, per_cnt_inc_s;
    logic [CNTWIDTH-1:0]  per_act_r, per_act_nxt_s;
    logic [CNTWIDTH-1:0]  inj_cnt_r, inj_cnt_nxt_s;
    int                   bit_idx_s;

    // Sequence datapath: candidate word and advanced history for this cycle.
    always_comb begin
        seed_fix_s    = (bus.seed == 7'h00) ? 7'h7F : bus.seed;
        hist_src_s    = (state_r == ST_LOAD) ? seed_fix_s : hist_r;
        run_word_s    = (state_r == ST_RUN) && bus.enable;
        slip_s        = run_word_s && bus.slip;
        ext_s         = prbs_extend(hist_src_s);
        if (slip_s) begin
            word_s     = ext_s[8 +: WORDWIDTH];
            hist_adv_s = ext_s[WORDWIDTH + 1 +: 7];
        end else begin
            word_s     = ext_s[7 +: WORDWIDTH];
            hist_adv_s = ext_s[WORDWIDTH +: 7];
        end
        // Periodic event fires when the 1-based word count reaches the active period.
        per_cnt_inc_s = per_cnt_r + CNTWIDTH'(1'b1);
        per_evt_s     = run_word_s && (per_act_r != {CNTWIDTH{1'b0}}) && (per_cnt_inc_s == per_act_r);
        // Manual and periodic requests on the same word collapse into one flip.
        flip_s        = run_word_s && (bus.inj_req || per_evt_s);
        bit_idx_s     = 32'(bus.inj_bit) % WORDWIDTH;
        if (flip_s) begin
            mask_s = {{(WORDWIDTH - 1){1'b0}}, 1'b1} << bit_idx_s;
        end else begin
            mask_s = {WORDWIDTH{1'b0}};
        end
    end

    // FSM next state and next values of all registers.
    always_comb begin
        state_nxt_s   = state_r;
        hist_nxt_s    = hist_r;
        dout_nxt_s    = dout_r;
        per_cnt_nxt_s = per_cnt_r;
        per_act_nxt_s = per_act_r;
        inj_cnt_nxt_s = inj_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // The first word is generated straight from the seed.
                state_nxt_s   = ST_RUN;
                hist_nxt_s    = hist_adv_s;
                dout_nxt_s    = word_s;
                per_cnt_nxt_s = {CNTWIDTH{1'b0}};
                per_act_nxt_s = bus.inj_period;
            end
            ST_RUN: begin
                if (bus.enable) begin
                    state_nxt_s = ST_RUN;
                    hist_nxt_s  = hist_adv_s;
                    dout_nxt_s  = word_s ^ mask_s;
                    // A new period is only adopted at a wrap (or while disabled).
                    if ((per_act_r == {CNTWIDTH{1'b0}}) || per_evt_s) begin
                        per_cnt_nxt_s = {CNTWIDTH{1'b0}};
                        per_act_nxt_s = bus.inj_period;
                    end else begin
                        per_cnt_nxt_s = per_cnt_inc_s;
                    end
                    if (flip_s && (inj_cnt_r != {CNTWIDTH{1'b1}})) begin
                        inj_cnt_nxt_s = inj_cnt_r + CNTWIDTH'(1'b1);
                    end else begin
                        inj_cnt_nxt_s = inj_cnt_r;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        valid_nxt_s = (state_nxt_s == ST_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            hist_r    <= 7'h00;
            dout_r    <= {WORDWIDTH{1'b0}};
            valid_r   <= 1'b0;
            per_cnt_r <= {CNTWIDTH{1'b0}};
            per_act_r <= {CNTWIDTH{1'b0}};
            inj_cnt_r <= {CNTWIDTH{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            hist_r    <= hist_nxt_s;
            dout_r    <= dout_nxt_s;
            valid_r   <= valid_nxt_s;
            per_cnt_r <= per_cnt_nxt_s;
            per_act_r <= per_act_nxt_s;
            inj_cnt_r <= inj_cnt_nxt_s;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = valid_r;
    assign bus.inj_count  = inj_cnt_r;

endmodule
